// File: rtl/mac_pipe_param.sv
// Pipelined signed multiply-accumulate with saturating accumulation and an
// optional vector mode that emits a dot product every VEC_LEN valid inputs.
module mac_pipe_param #(
  parameter int WIDTH       = 14,  // 2..32
  parameter int ACC_WIDTH   = 28,  // >= 2*WIDTH
  parameter int MULT_STAGES = 2,   // 1..4
  parameter int VEC_LEN     = 0    // 0 = free-running accumulation
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 valid_in,
  output logic [ACC_WIDTH-1:0] f,
  output logic                 valid_out,
  output logic                 sat_flag
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = (VEC_LEN > 0) ? CNT_W'(VEC_LEN - 1) : '0;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Stage 0 operands and the multiplier pipeline.
  logic signed [WIDTH-1:0]     a_q, b_q;
  logic signed [PW-1:0]        prod_q [MULT_STAGES];
  logic [MULT_STAGES:0]        vld_q;
  logic signed [PW-1:0]        prod_d;

  // Accumulator and output stage.
  logic signed [ACC_WIDTH-1:0] acc_q, f_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        sticky_q, sticky_d;
  logic                        valid_out_q, sat_flag_q;

  logic                        fire, first_elem, last_elem;
  logic signed [ACC_WIDTH-1:0] base, prod_ext, sum_raw, sum_sat;
  logic                        pos_ovf, neg_ovf, step_sat;

  // Both operands are sign-extended first, so the product is exact.
  assign prod_d = PW'(a_q) * PW'(b_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
      // NOTE: the product pipeline is an array, yet it still needs an explicit
      // per-entry reset loop; otherwise it powers up with stale data.
      for (int i = 0; i < MULT_STAGES; i++) prod_q[i] <= '0;
    end else begin
      if (valid_in) begin
        a_q <= a;
        b_q <= b;
      end
      // NOTE: non-blocking assignment lets each stage read the previous
      // stage's old value, which is what makes this a shift chain.
      vld_q     <= {vld_q[MULT_STAGES-1:0], valid_in};
      prod_q[0] <= prod_d;
      for (int i = 1; i < MULT_STAGES; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  // The tail of the valid chain lines up with the last product register.
  assign fire       = vld_q[MULT_STAGES];
  assign first_elem = (VEC_LEN > 0) && (cnt_q == '0);
  assign last_elem  = (VEC_LEN > 0) && (cnt_q == LAST_IDX);

  // NOTE: every signal driven here is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    base     = first_elem ? '0 : acc_q;
    prod_ext = ACC_WIDTH'(prod_q[MULT_STAGES-1]);
    sum_raw  = base + prod_ext;
    pos_ovf  = !base[ACC_WIDTH-1] && !prod_ext[ACC_WIDTH-1] && sum_raw[ACC_WIDTH-1];
    neg_ovf  = base[ACC_WIDTH-1] && prod_ext[ACC_WIDTH-1] && !sum_raw[ACC_WIDTH-1];
    step_sat = pos_ovf | neg_ovf;
    if (pos_ovf)      sum_sat = ACC_MAX;
    else if (neg_ovf) sum_sat = ACC_MIN;
    else              sum_sat = sum_raw;
    sticky_d = (first_elem ? 1'b0 : sticky_q) | step_sat;
    cnt_d    = ((VEC_LEN == 0) || last_elem) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      f_q         <= '0;
      valid_out_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      if (fire) begin
        acc_q    <= sum_sat;
        cnt_q    <= cnt_d;
        sticky_q <= sticky_d;
        if (VEC_LEN == 0) begin
          f_q         <= sum_sat;
          valid_out_q <= 1'b1;
          sat_flag_q  <= step_sat;
        end else if (last_elem) begin
          // f only changes at a vector boundary; mid-vector sums stay internal.
          f_q         <= sum_sat;
          valid_out_q <= 1'b1;
          sat_flag_q  <= sticky_d;
        end
      end
    end
  end

  assign f         = f_q;
  assign valid_out = valid_out_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_mac_pipe_param.sv
// Directed bench for mac_pipe_param: one free-running instance and one
// VEC_LEN=4 instance, each checked against a queue of expected results.
module tb_mac_pipe_param;

  localparam int LAT = 3;  // MULT_STAGES + 1 at the default settings

  typedef struct {
    logic signed [27:0] f;
    logic               sat;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst0 = 1'b1, v0 = 1'b1;
  logic [13:0]        a0 = 14'd5, b0 = 14'd5;
  logic signed [27:0] f0;
  logic               vo0, sat0;

  logic               rst4 = 1'b1, v4 = 1'b1;
  logic [13:0]        a4 = 14'd5, b4 = 14'd5;
  logic signed [27:0] f4;
  logic               vo4, sat4;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic rst0_s = 1'b0, rst4_s = 1'b0;
  exp_t q0[$], q4[$];
  exp_t e0, e4;
  logic signed [27:0] hold0 = '0, hold4 = '0;

  mac_pipe_param #(.WIDTH(14), .ACC_WIDTH(28), .MULT_STAGES(2), .VEC_LEN(0)) u_free (
    .clk(clk), .reset(rst0), .a(a0), .b(b0), .valid_in(v0),
    .f(f0), .valid_out(vo0), .sat_flag(sat0));

  mac_pipe_param #(.WIDTH(14), .ACC_WIDTH(28), .MULT_STAGES(2), .VEC_LEN(4)) u_vec (
    .clk(clk), .reset(rst4), .a(a4), .b(b4), .valid_in(v4),
    .f(f4), .valid_out(vo4), .sat_flag(sat4));

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle on a DUT; optionally queue the result it must produce.
  task automatic step0(input int av, input int bv, input logic v,
                       input logic push, input int ef, input logic es);
    a0 = 14'(av); b0 = 14'(bv); v0 = v;
    if (push) q0.push_back('{28'(ef), es, cyc + 1 + LAT});
    @(negedge clk);
  endtask

  task automatic step4(input int av, input int bv, input logic v,
                       input logic push, input int ef, input logic es);
    a4 = 14'(av); b4 = 14'(bv); v4 = v;
    if (push) q4.push_back('{28'(ef), es, cyc + 1 + LAT});
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst0_s <= rst0;
    rst4_s <= rst4;
  end

  always @(negedge clk) begin
    if (rst0_s) begin
      check("free_rst_f", f0, 0);
      check("free_rst_valid", vo0, 0);
      check("free_rst_sat", sat0, 0);
      hold0 = '0;
    end else if (vo0 === 1'b1) begin
      if (q0.size() == 0) check("free_spurious_pulse", vo0, 0);
      else begin
        e0 = q0.pop_front();
        check("free_f", f0, e0.f);
        check("free_sat", sat0, e0.sat);
        check("free_latency", cyc, e0.cyc);
        hold0 = e0.f;
      end
    end else begin
      check("free_hold_f", f0, hold0);
      check("free_idle_sat", sat0, 0);
      if (q0.size() > 0 && q0[0].cyc <= cyc) begin
        check("free_missed_pulse", vo0, 1);
        void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst4_s) begin
      check("vec_rst_f", f4, 0);
      check("vec_rst_valid", vo4, 0);
      check("vec_rst_sat", sat4, 0);
      hold4 = '0;
    end else if (vo4 === 1'b1) begin
      if (q4.size() == 0) check("vec_spurious_pulse", vo4, 0);
      else begin
        e4 = q4.pop_front();
        check("vec_f", f4, e4.f);
        check("vec_sat", sat4, e4.sat);
        check("vec_latency", cyc, e4.cyc);
        hold4 = e4.f;
      end
    end else begin
      check("vec_hold_f", f4, hold4);
      check("vec_idle_sat", sat4, 0);
      if (q4.size() > 0 && q4[0].cyc <= cyc) begin
        check("vec_missed_pulse", vo4, 1);
        void'(q4.pop_front());
      end
    end
  end

  initial begin
    // Reset held three edges with a valid sample present: reset wins.
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst4 = 1'b0; v0 = 1'b0; v4 = 1'b0;
    repeat (3) @(negedge clk);

    // Free-running latency and bubble handling.
    step0(3, 4, 1, 1, 12, 0);
    step0(-2, 5, 1, 1, 2, 0);
    step0(0, 0, 0, 0, 0, 0);
    step0(7, -1, 1, 1, -5, 0);
    repeat (5) step0(0, 0, 0, 0, 0, 0);

    // Positive saturation, then the clamp persists.
    rst0 = 1'b1; step0(0, 0, 0, 0, 0, 0); rst0 = 1'b0;
    step0(-8192, -8192, 1, 1, 67108864, 0);
    step0(-8192, -8192, 1, 1, 134217727, 1);
    step0(-8192, -8192, 1, 1, 134217727, 1);
    repeat (5) step0(0, 0, 0, 0, 0, 0);

    // Negative saturation on the third step only.
    rst0 = 1'b1; step0(0, 0, 0, 0, 0, 0); rst0 = 1'b0;
    step0(-8192, 8191, 1, 1, -67100672, 0);
    step0(-8192, 8191, 1, 1, -134201344, 0);
    step0(-8192, 8191, 1, 1, -134217728, 1);
    repeat (5) step0(0, 0, 0, 0, 0, 0);

    // Vector mode: two dot products of four, with a bubble inside the first.
    step4(1, 1, 1, 0, 0, 0);
    step4(2, 2, 1, 0, 0, 0);
    step4(0, 0, 0, 0, 0, 0);
    step4(3, 3, 1, 0, 0, 0);
    step4(4, 4, 1, 1, 30, 0);
    step4(5, 5, 1, 0, 0, 0);
    step4(1, 1, 1, 0, 0, 0);
    step4(1, 1, 1, 0, 0, 0);
    step4(1, 1, 1, 1, 28, 0);
    repeat (5) step4(0, 0, 0, 0, 0, 0);

    // Reset while two samples are still in the multiplier pipeline.
    step4(10, 10, 1, 0, 0, 0);
    step4(10, 10, 1, 0, 0, 0);
    rst4 = 1'b1; step4(0, 0, 0, 0, 0, 0); rst4 = 1'b0;
    repeat (3) step4(1, 2, 1, 0, 0, 0);
    step4(1, 2, 1, 1, 8, 0);
    repeat (5) step4(0, 0, 0, 0, 0, 0);

    // Reset after part of a vector has already accumulated.
    repeat (3) step4(10, 10, 1, 0, 0, 0);
    repeat (2) step4(0, 0, 0, 0, 0, 0);
    rst4 = 1'b1; step4(0, 0, 0, 0, 0, 0); rst4 = 1'b0;
    repeat (3) step4(1, 2, 1, 0, 0, 0);
    step4(1, 2, 1, 1, 8, 0);

    for (int i = 0; i < 20 && (q0.size() != 0 || q4.size() != 0); i++) @(negedge clk);
    check("free_queue_drained", q0.size(), 0);
    check("vec_queue_drained", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_pipe_param.md
# mac_pipe_param

Parametrised, fully pipelined signed multiply-accumulate unit with saturating accumulation. It is the generalised successor of the fixed 14-bit / 28-bit two-stage MAC. Operand width, accumulator width and multiplier pipeline depth are all configurable, and a vector mode emits one dot-product result every VEC_LEN valid inputs, then restarts accumulation automatically. It sits directly behind the operand fetch logic of the convolution datapath and feeds the result collector.

## Interface
- WIDTH, 14: signed operand width (a, b); 2..32
- ACC_WIDTH, 28: signed accumulator / output width; must be >= 2*WIDTH
- MULT_STAGES, 2: multiplier pipeline register stages; 1..4
- VEC_LEN, 0: 0 = free-running accumulation; N>0 = emit and restart every N valid inputs
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- a  input  WIDTH  signed operand A
- b  input  WIDTH  signed operand B
- valid_in  input  1  a/b valid this cycle; no backpressure
- f  output  ACC_WIDTH  signed accumulated result
- valid_out  output  1  one-cycle pulse: f holds a new result
- sat_flag  output  1  qualified by valid_out; saturation occurred in the reported result

## Operation
- Reset values: f=0, valid_out=0, sat_flag=0. Input registers, multiplier pipeline, valid shift chain, accumulator, element counter and sticky saturation bit are also 0.
- Stage 0, input register: a, b captured only when valid_in=1; otherwise held.
- Stages 1..MULT_STAGES: product = a*b, full 2*WIDTH signed, sign-extended to ACC_WIDTH. The product cannot overflow: (-2^(WIDTH-1))^2 fits in 2*WIDTH bits.
- Valid chain: a shift register of MULT_STAGES+1 bits tracks each sample. Bubbles (valid_in=0) propagate as 0 and never touch the accumulator.
- Accumulate stage fires only when the chain tail is 1:
  - base = 0 if the element counter is 0 (VEC_LEN>0), else acc. With VEC_LEN=0, base is always acc.
  - sum = base + product. Positive overflow (both operands >0, sum <0) → 2^(ACC_WIDTH-1)-1. Negative overflow (both <0, sum >=0) → -2^(ACC_WIDTH-1).
  - acc <= saturated sum. The sticky saturation bit is set if this step saturated. In vector mode it is cleared at element 0 before the OR.
- VEC_LEN=0 outputs: f <= saturated sum and valid_out=1 on every accumulate. sat_flag reports this step only.
- VEC_LEN=N outputs:
  - The element counter counts 0..N-1 and wraps to 0 after element N-1.
  - Only on element N-1: f <= saturated sum, valid_out=1, sat_flag = sticky OR this step.
  - f holds the last completed vector result between pulses. The internal acc is not visible at f mid-vector.
- Saturated values persist: later accumulation continues from the clamp value (no wrap).
- Reset mid-operation: every in-flight sample is discarded, and the counter and acc return to 0. The first valid_in after reset starts a new vector.
- Simultaneous reset and valid_in: reset wins, and the sample is dropped.

## Timing
- Throughput: one sample per clock; back-to-back valid_in allowed indefinitely.
- Latency: valid_in=1 sampled at edge n produces the accumulate at edge n+MULT_STAGES+1. f and valid_out are visible after that edge (defaults: n+3).
- valid_out is high for exactly one cycle per result. Consecutive results give consecutive pulses with no gap.
- sat_flag is meaningful only while valid_out=1 and is 0 otherwise.
- Reset asserted at edge r: all outputs are 0 after edge r. No valid_out occurs until MULT_STAGES+1 edges after the first post-reset valid sample.

## Test plan
- Reset: hold reset 3 cycles with valid_in=1, a=b=5 → f=0, valid_out=0, sat_flag=0 throughout and for 3 cycles after release with valid_in=0.
- Free-run latency (defaults, VEC_LEN=0): (3,4) at edge n, (-2,5) at n+1, bubble, then (7,-1) → valid_out pulses at n+3 and n+4 with f=12 then 2. Idle cycle with f held at 2, then pulse with f=-5.
- Positive saturation: a=b=-8192 for 3 consecutive cycles → f=67108864 (sat_flag=0), then 134217727 (sat_flag=1), then 134217727 (sat_flag=1).
- Negative saturation: a=-8192, b=8191 for 3 cycles → f=-67100672, -134201344, then -134217728 with sat_flag=1 on the third only.
- Vector mode (VEC_LEN=4): (1,1),(2,2),(3,3),(4,4),(5,5),(1,1),(1,1),(1,1) with one bubble inserted → exactly two valid_out pulses, f=30 then f=28. f holds 30 between pulses.
- Reset mid-vector (VEC_LEN=4): two valid samples (10,10), reset for 1 cycle during flight, then four (1,2) → no pulse from the pre-reset samples; single pulse with f=8, sat_flag=0.
